// File: rtl/datamemory_lsu.sv
// Data memory for the MEM stage: byte-enabled storage behind a fixed-latency request/response
// handshake, with lane shifting, sign/zero extension and misaligned/illegal access faulting.
module datamemory_lsu #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 9,
  parameter int LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_fault
);
  localparam int NB    = DATA_W / 8;
  localparam int LW    = $clog2(NB);
  localparam int WORDS = 2 ** (ADDR_W - LW);
  localparam logic [2:0] CNT_INIT = 3'(LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_RESP = 2'd2} state_e;

  logic [DATA_W-1:0] mem_q [WORDS];

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_fault_q, rsp_fault_d;
  logic [DATA_W-1:0] pend_data_q, pend_data_d;
  logic              pend_fault_q, pend_fault_d;

  logic                 accept_s;
  logic [LW-1:0]        lane_s;
  logic [ADDR_W-LW-1:0] widx_s;
  logic [1:0]           size_s;
  logic                 fault_s;
  logic [DATA_W-1:0]    rd_word_s;
  logic [DATA_W-1:0]    load_s;
  logic [DATA_W-1:0]    result_s;
  logic                 wr_en_s;
  logic [DATA_W-1:0]    wdata_sh_s;
  logic [NB-1:0]        be_s;

  function automatic logic is_legal(input logic we, input logic [2:0] f3);
    logic ok;
    if (we) begin
      case (f3)
        3'b000, 3'b001, 3'b010: ok = 1'b1;
        3'b011:                 ok = (DATA_W == 64);
        default:                ok = 1'b0;
      endcase
    end else begin
      case (f3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: ok = 1'b1;
        3'b011, 3'b110:                         ok = (DATA_W == 64);
        default:                                ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] a);
    logic mis;
    case (size)
      2'd0:    mis = 1'b0;
      2'd1:    mis = a[0];
      2'd2:    mis = |a[1:0];
      default: mis = |a[2:0];
    endcase
    return mis;
  endfunction

  // Field sits right-aligned in v; bits above the access width take the sign bit or zero.
  function automatic logic [DATA_W-1:0] extend(input logic [DATA_W-1:0] v, input logic [1:0] size,
                                               input logic sgn);
    logic [DATA_W-1:0] r;
    logic              sb;
    int                w;
    case (size)
      2'd0:    sb = v[7];
      2'd1:    sb = v[15];
      default: sb = v[31];
    endcase
    w = 32'sd8 << size;
    for (int i = 0; i < DATA_W; i++) begin
      if (i < w) begin
        r[i] = v[i];
      end else begin
        r[i] = sgn & sb;
      end
    end
    return r;
  endfunction

  assign accept_s = req_valid && req_ready_q;
  assign lane_s   = req_addr[LW-1:0];
  assign widx_s   = req_addr[ADDR_W-1:LW];
  assign size_s   = req_funct3[1:0];

  // Request decode: fault detection, load extraction and store lane placement.
  always_comb begin
    fault_s    = !is_legal(req_we, req_funct3) || is_misaligned(size_s, req_addr[2:0]);
    rd_word_s  = mem_q[widx_s];
    load_s     = extend(rd_word_s >> {lane_s, 3'b000}, size_s, !req_funct3[2]);
    wdata_sh_s = req_wdata << {lane_s, 3'b000};
    wr_en_s    = accept_s && req_we && !fault_s;
    if (req_we || fault_s) begin
      result_s = {DATA_W{1'b0}};
    end else begin
      result_s = load_s;
    end
    for (int b = 0; b < NB; b++) begin
      be_s[b] = (b >= int'(lane_s)) && (b < int'(lane_s) + (32'sd1 << size_s));
    end
  end

  // Storage array: byte-enabled write at the acceptance edge, never reset.
  always_ff @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (wr_en_s && be_s[b]) begin
        mem_q[widx_s][8*b +: 8] <= wdata_sh_s[8*b +: 8];
      end
    end
  end

  // Handshake sequencing: the load result is captured at acceptance and released at RESP.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rsp_valid_d  = 1'b0;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_fault_d  = rsp_fault_q;
    pend_data_d  = pend_data_q;
    pend_fault_d = pend_fault_q;
    case (state_q)
      S_WAIT: begin
        if (cnt_q > 3'd1) begin
          cnt_d = cnt_q - 3'd1;
        end else begin
          state_d     = S_RESP;
          cnt_d       = 3'd0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = pend_data_q;
          rsp_fault_d = pend_fault_q;
        end
      end
      S_IDLE, S_RESP: begin
        if (accept_s) begin
          if (LATENCY == 1) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = result_s;
            rsp_fault_d = fault_s;
          end else begin
            state_d      = S_WAIT;
            cnt_d        = CNT_INIT;
            pend_data_d  = result_s;
            pend_fault_d = fault_s;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 3'd0;
      end
    endcase
    req_ready_d = (state_d != S_WAIT);
  end

  // Control and response registers; a reset drops any pending response.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= 3'd0;
      req_ready_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= {DATA_W{1'b0}};
      rsp_fault_q  <= 1'b0;
      pend_data_q  <= {DATA_W{1'b0}};
      pend_fault_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_ready_q  <= req_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_fault_q  <= rsp_fault_d;
      pend_data_q  <= pend_data_d;
      pend_fault_q <= pend_fault_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_fault = rsp_fault_q;

endmodule
